dct_coef_engine: RTL
====================

// Module: dct_coef_engine
// PURPOSE
//  Streaming 2-D DCT-II coefficient engine for one (k1,k2) per pass over an N x N pixel block.
//  - Generates cos(k1)*cos(k2) product terms on the fly from a 1-D cosine ROM; no per-(k1,k2) LUT.
//  - Multiply-accumulates N*N signed pixels and returns the raw coefficient over a valid/ready handshake.
//  - Sits between the pixel block buffer and the coefficient quantiser.
// PARAMETERS
//  N      8   block dimension; legal values 4, 8, 16; k and n indices are $clog2(N) bits
//  PIX_W  9   signed, level-shifted pixel width
//  FRAC   8   fraction bits of cosine and product terms (Q.FRAC)
//  COS_W  16  signed 1-D cosine / product term width
//  ACC_W  32  signed accumulator and coefficient width
// PORTS
//  clk          in   1           rising-edge clock
//  reset        in   1           synchronous, active-high
//  start_valid  in   1           request a pass for k1/k2
//  start_ready  out  1           high only in IDLE
//  k1, k2       in   $clog2(N)   frequency indices, sampled on start handshake
//  pix_valid    in   1           pixel available
//  pix_ready    out  1           high only in ACCUM while pixels remain
//  pix          in   PIX_W       signed pixel, raster order (n1 outer, n2 inner)
//  coef_valid   out  1           coefficient available
//  coef_ready   in   1           downstream accepts coefficient
//  coef         out  ACC_W       sum of pix*term, Q.FRAC, signed
//  busy         out  1           state != IDLE
// BEHAVIOUR
//  - Reset (any cycle, including mid-pass): state=IDLE, counters=0, acc=0, pipe valid=0.
//    Outputs after reset: coef_valid=0, coef=0, pix_ready=0, start_ready=1, busy=0.
//  - States: IDLE -> ACCUM on start_valid&&start_ready (capture k1,k2; clear acc, n1, n2).
//    ACCUM -> DONE when the N*N-th product has been added. DONE -> IDLE on coef_valid&&coef_ready.
//  - start_valid outside IDLE is ignored, not queued.
//    A start in the same cycle as the DONE->IDLE handshake is not accepted (start_ready is still 0).
//  - Pixel accepted on pix_valid&&pix_ready. n2 increments each accept; on n2==N-1 it wraps to 0 and n1 increments.
//    pix_ready drops combinationally once N*N pixels have been accepted.
//  - Term: c1d[k][n] = round_half_up(|cos((2n+1)k*pi/2N)| * 2^FRAC), with a separate sign bit.
//    term = sign * ((|c1d[k1][n1]| * |c1d[k2][n2]|) >> FRAC), i.e. truncation toward zero.
//    This gives symmetric +/- values; k1=2,k2=4,N=8 yields +/-0x0A7 and +/-0x045.
//  - Pipeline stage 1 (edge after accept): p_reg = pix * term, sign-extended to ACC_W, plus p_vld.
//    Stage 2 (next edge): acc += p_reg when p_vld.
//  - Latency: last pixel accepted in cycle T -> coef_valid=1 in cycle T+2.
//  - coef = acc, registered. coef and coef_valid are held stable while coef_ready=0.
//    coef_valid deasserts the cycle after the handshake.
//  - pix_valid gaps (bubbles) are allowed anywhere. The pipeline advances on every clock regardless of coef_ready.
//  - Overflow is impossible for the defaults (|sum| < 2^23). No saturation logic.
// STRUCTURE
//  - dct_pkg: N-generic c1d magnitude/sign tables as localparam arrays built by a constant function, plus state_t enum.
//  - Sub-module dct_cos_rom: combinational (k,n) -> {sign, magnitude}. Instantiated twice (k1/n1 and k2/n2).
//  - Top level: FSM, counters, product stage, accumulator, output register.
// TESTING
//  - DC: k1=k2=0, all 64 pix=1 -> coef=16384 (0x4000).
//  - Single impulse: k1=2,k2=4, pix(0,0)=1, others 0 -> coef=167.
//    Same with pix(0,1)=10 only -> coef=-1670.
//  - Cancellation: k1=2,k2=4, all pix=100 -> coef=0.
//    Random pix vs. a double-precision model with truncated terms -> exact match.
//  - Handshakes: random pix_valid bubbles plus coef_ready low for 5 cycles.
//    Coef stable and start_ready=0 throughout; no pixel accepted past 64; start during DONE is ignored.
//  - Latency: last pix accepted at cycle T -> coef_valid rises at exactly T+2 with coef_ready=1.
//  - Reset mid-pass: reset after 20 pixels, then a full DC pass with pix=2 -> coef=32768.
//    No residue from the aborted pass; outputs match reset values during the reset cycle.

Source files
------------

// File: rtl/dct_pkg.sv
// Shared types and cosine tables for the 2-D DCT coefficient engine.
// The 1-D cosine tables are derived from one quarter-wave table of
// round_half_up(cos(j*pi/32) * 256). Every legal block size (4, 8, 16)
// samples the cosine at whole multiples of pi/32, so this one table covers them all.
package dct_pkg;

   localparam int MAX_N  = 16;   // largest supported block dimension
   localparam int TAB_AW = 4;    // index width of the MAX_N-sized tables
   localparam int TAB_W  = 9;    // magnitude width; the largest entry is 256 (1.0 in Q8)

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   typedef logic [MAX_N-1:0][MAX_N-1:0][TAB_W-1:0] mag_tab_t;
   typedef logic [MAX_N-1:0][MAX_N-1:0]            sgn_tab_t;

   // Quarter wave: round_half_up(cos(j*pi/32) * 2^8), j = 0..16.
   function automatic logic [TAB_W-1:0] qcos(input int j);
      logic [TAB_W-1:0] v;
      case (j)
         0:       v = 9'd256;
         1:       v = 9'd255;
         2:       v = 9'd251;
         3:       v = 9'd245;
         4:       v = 9'd237;
         5:       v = 9'd226;
         6:       v = 9'd213;
         7:       v = 9'd198;
         8:       v = 9'd181;
         9:       v = 9'd162;
         10:      v = 9'd142;
         11:      v = 9'd121;
         12:      v = 9'd98;
         13:      v = 9'd74;
         14:      v = 9'd50;
         15:      v = 9'd25;
         default: v = 9'd0;
      endcase
      return v;
   endfunction

   // Angle (2n+1)*k*pi/(2N), expressed in pi/32 steps and reduced to one period (64 steps).
   function automatic int phase(input int n_dim, input int k, input int n);
      return ((2*n + 1) * k * (16 / n_dim)) % 64;
   endfunction

   // |c1d[k][n]| for an n_dim x n_dim block; entries beyond n_dim are zero.
   function automatic mag_tab_t build_mag(input int n_dim);
      mag_tab_t t;
      int       j;
      t = '0;
      for (int k = 0; k < MAX_N; k++) begin
         for (int n = 0; n < MAX_N; n++) begin
            if (k < n_dim && n < n_dim) begin
               j = phase(n_dim, k, n);
               if (j <= 16)      t[k][n] = qcos(j);
               else if (j <= 32) t[k][n] = qcos(32 - j);
               else if (j <= 48) t[k][n] = qcos(j - 32);
               else              t[k][n] = qcos(64 - j);
            end
         end
      end
      return t;
   endfunction

   // Sign of c1d[k][n]: negative strictly between pi/2 and 3pi/2.
   function automatic sgn_tab_t build_neg(input int n_dim);
      sgn_tab_t t;
      int       j;
      t = '0;
      for (int k = 0; k < MAX_N; k++) begin
         for (int n = 0; n < MAX_N; n++) begin
            if (k < n_dim && n < n_dim) begin
               j = phase(n_dim, k, n);
               t[k][n] = (j > 16) && (j < 48);
            end
         end
      end
      return t;
   endfunction

endpackage

// File: rtl/dct_coef_engine_cos_rom.sv
// Combinational 1-D cosine lookup: (k, n) -> {sign, |c1d[k][n]|} in Q.FRAC.
module dct_cos_rom
   import dct_pkg::*;
#(
   parameter int N     = 8,
   parameter int COS_W = 16
)(
   input  logic [$clog2(N)-1:0] i_k,
   input  logic [$clog2(N)-1:0] i_n,
   output logic                 o_neg,
   output logic [COS_W-1:0]     o_mag
);

   localparam mag_tab_t MAG = build_mag(N);
   localparam sgn_tab_t NEG = build_neg(N);

   logic [TAB_AW-1:0] w_k;
   logic [TAB_AW-1:0] w_n;

   assign w_k   = TAB_AW'(i_k);
   assign w_n   = TAB_AW'(i_n);
   assign o_mag = COS_W'(MAG[w_k][w_n]);
   assign o_neg = NEG[w_k][w_n];

endmodule

// File: rtl/dct_coef_engine.sv
// Streaming 2-D DCT-II coefficient engine: one (k1,k2) coefficient per pass
// over an N x N raster-ordered pixel block. Product terms are formed on the fly
// from two 1-D cosine lookups; a two-stage multiply/accumulate pipeline feeds a
// held output register behind a valid/ready handshake.
module dct_coef_engine
   import dct_pkg::*;
#(
   parameter int N     = 8,
   parameter int PIX_W = 9,
   parameter int FRAC  = 8,
   parameter int COS_W = 16,
   parameter int ACC_W = 32
)(
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_start_valid,
   output logic                 o_start_ready,
   input  logic [$clog2(N)-1:0] i_k1,
   input  logic [$clog2(N)-1:0] i_k2,
   input  logic                 i_pix_valid,
   output logic                 o_pix_ready,
   input  logic [PIX_W-1:0]     i_pix,
   output logic                 o_coef_valid,
   input  logic                 i_coef_ready,
   output logic [ACC_W-1:0]     o_coef,
   output logic                 o_busy
);

   localparam int KW   = $clog2(N);
   localparam int NPIX = N * N;
   localparam int CW   = $clog2(NPIX + 1);

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [KW-1:0]           r_k1, r_k2, r_n1, r_n2;
   logic [CW-1:0]           r_cnt;

   logic                    w_start, w_accept, w_last_pix, w_last_add, w_coef_hs;

   logic                    w_neg1, w_neg2;
   logic [COS_W-1:0]        w_mag1, w_mag2, w_tmag;
   logic [2*COS_W-1:0]      w_mm;
   logic signed [COS_W-1:0] w_term;
   logic signed [PIX_W-1:0] w_pix_s;
   logic signed [ACC_W-1:0] w_pix_x, w_term_x, w_prod;

   logic signed [ACC_W-1:0] r_p, r_acc, r_coef;
   logic                    r_p_vld, r_p_last, r_coef_valid;

   // Cosine for the row index and for the column index of the pixel being accepted.
   dct_cos_rom #(.N(N), .COS_W(COS_W)) u_rom1 (
      .i_k(r_k1), .i_n(r_n1), .o_neg(w_neg1), .o_mag(w_mag1)
   );
   dct_cos_rom #(.N(N), .COS_W(COS_W)) u_rom2 (
      .i_k(r_k2), .i_n(r_n2), .o_neg(w_neg2), .o_mag(w_mag2)
   );

   // Magnitudes are multiplied and truncated before the sign is applied, so
   // +x and -x terms round identically (truncation toward zero).
   assign w_mm     = w_mag1 * w_mag2;
   assign w_tmag   = COS_W'(w_mm >> FRAC);
   assign w_term   = (w_neg1 ^ w_neg2) ? -$signed(w_tmag) : $signed(w_tmag);
   assign w_pix_s  = i_pix;
   assign w_pix_x  = ACC_W'(w_pix_s);
   assign w_term_x = ACC_W'(w_term);
   assign w_prod   = w_pix_x * w_term_x;

   assign w_start    = i_start_valid && o_start_ready;
   assign w_accept   = i_pix_valid && o_pix_ready;
   assign w_last_pix = w_accept && (r_cnt == CW'(NPIX - 1));
   assign w_last_add = r_p_vld && r_p_last;
   assign w_coef_hs  = r_coef_valid && i_coef_ready;

   assign o_coef_valid = r_coef_valid;
   assign o_coef       = r_coef;

   // Next state and state-derived handshake outputs.
   always_comb begin
      w_state_nxt   = r_state;
      o_start_ready = 1'b0;
      o_pix_ready   = 1'b0;
      o_busy        = 1'b1;
      case (r_state)
         S_IDLE: begin
            o_start_ready = 1'b1;
            o_busy        = 1'b0;
            if (w_start) w_state_nxt = S_ACCUM;
         end
         S_ACCUM: begin
            o_pix_ready = (r_cnt < CW'(NPIX));
            if (w_last_add) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            if (w_coef_hs) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Frequency capture and raster counters (n2 inner, n1 outer).
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_k1  <= '0;
         r_k2  <= '0;
         r_n1  <= '0;
         r_n2  <= '0;
         r_cnt <= '0;
      end else if (w_start) begin
         r_k1  <= i_k1;
         r_k2  <= i_k2;
         r_n1  <= '0;
         r_n2  <= '0;
         r_cnt <= '0;
      end else if (w_accept) begin
         r_cnt <= r_cnt + CW'(1);
         if (r_n2 == KW'(N - 1)) begin
            r_n2 <= '0;
            r_n1 <= r_n1 + KW'(1);
         end else begin
            r_n2 <= r_n2 + KW'(1);
         end
      end
   end

   // Product stage; the valid bits advance every clock, gaps included.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_p      <= '0;
         r_p_vld  <= 1'b0;
         r_p_last <= 1'b0;
      end else begin
         r_p_vld  <= w_accept;
         r_p_last <= w_last_pix;
         if (w_accept) r_p <= w_prod;
      end
   end

   // Accumulator; cleared when a new pass is accepted.
   always_ff @(posedge i_clk) begin
      if (i_reset)      r_acc <= '0;
      else if (w_start) r_acc <= '0;
      else if (r_p_vld) r_acc <= r_acc + r_p;
   end

   // Output register: loaded with the completed sum, held until taken.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_coef       <= '0;
         r_coef_valid <= 1'b0;
      end else if (w_last_add) begin
         r_coef       <= r_acc + r_p;
         r_coef_valid <= 1'b1;
      end else if (w_coef_hs) begin
         r_coef_valid <= 1'b0;
      end
   end

endmodule
